// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refill (I) and data cache (D).
// Define MEM_ARB_TIMEOUT_EN to abort a SERVE that exceeds TIMEOUT_CYCLES with err_o set.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [29:0]           i_addr_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_ack_o,
  output logic                  i_busywait_o,
  input  logic                  d_req_i,
  input  logic [3:0]            d_we_i,
  input  logic [29:0]           d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_ack_o,
  output logic                  d_busywait_o,
  output logic                  mem_req_o,
  output logic [3:0]            mem_we_o,
  output logic [29:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  i_err_o,
  output logic                  d_err_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a requester holds req and payload until the cycle its ack_o pulses;
  // mem_req_o and its payload stay constant until mem_ack_i pulses for one cycle.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] TMO_RDATA = DATA_WIDTH'(32'h0BADC0DE);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_grant;
  logic                    w_grant_d;
  logic                    w_done;
  logic                    w_timeout;
  logic                    r_owner_d;
  logic                    r_last_d;
  logic                    r_mem_req;
  logic [3:0]              r_mem_we;
  logic [29:0]             r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [DATA_WIDTH-1:0]   r_i_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;
  logic                    r_i_ack;
  logic                    r_d_ack;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_i || d_req_i) begin
          w_grant      = 1'b1;
          // On a tie D wins unless D was the previous grant.
          w_grant_d    = d_req_i && (!i_req_i || !r_last_d);
          w_state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (mem_ack_i) begin
          w_done       = 1'b1;
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_grant) begin
        r_owner_d   <= w_grant_d;
        r_last_d    <= w_grant_d;
        r_mem_req   <= 1'b1;
        r_mem_addr  <= w_grant_d ? d_addr_i : i_addr_i;
        r_mem_we    <= w_grant_d ? d_we_i : 4'b0000;
        r_mem_wdata <= w_grant_d ? d_wdata_i : '0;
      end
      if (w_done || w_timeout) begin
        r_mem_req <= 1'b0;
        if (r_owner_d) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= w_done ? mem_rdata_i : TMO_RDATA;
        end else begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= w_done ? mem_rdata_i : TMO_RDATA;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_i_err;
  logic             r_d_err;

  // A real mem_ack_i in the limit cycle wins, so the timeout is masked by it.
  assign w_timeout = (r_state == ST_SERVE) && !mem_ack_i &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      r_i_err <= w_timeout && !r_owner_d;
      r_d_err <= w_timeout && r_owner_d;
      if (w_grant) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_SERVE && !mem_ack_i) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign i_err_o = r_i_err;
  assign d_err_o = r_d_err;
`else
  assign w_timeout = 1'b0;
  assign i_err_o   = 1'b0;
  assign d_err_o   = 1'b0;
`endif

  assign i_rdata_o    = r_i_rdata;
  assign d_rdata_o    = r_d_rdata;
  assign i_ack_o      = r_i_ack;
  assign d_ack_o      = r_d_ack;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign i_busywait_o = i_req_i & ~r_i_ack;
  assign d_busywait_o = d_req_i & ~r_d_ack;
  assign dbg_state_o  = r_state;

endmodule
